rate_tracker: RTL and testbench

Front-end measurement stage feeding `lockin`. It deglitches the synchronised input pin and emits filtered edge events, with and without a polarity qualifier. It measures edge-to-edge intervals in a saturating rate accumulator and holds the active rate register that `lockin` validates and updates through `update_rate`/`clear_rate`. It closes the measurement loop with `lockin` and sits between the pin synchroniser and `lockin`.

---
 rtl/clks_alot_p.sv | 12 +
 rtl/glitch_filter.sv | 63 ++++++
 rtl/rate_tracker.sv | 122 ++++++++++++
 tb/tb_rate_tracker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clks_alot_p.sv
// Shared types and widths for the clock-measurement front end.
package clks_alot_p;

  localparam int unsigned RATE_COUNTER_WIDTH = 16;

  typedef enum logic [1:0] {
    POL_RISING,
    POL_FALLING,
    POL_BOTH
  } polarity_select_e;

endpackage

// File: rtl/glitch_filter.sv
// Deglitches a synchronised pin: an edge is accepted only after depth_i extra stable samples.
module glitch_filter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             pin_i,
  input  logic [Width-1:0] depth_i,
  output logic             filtered_pin_o,
  output logic             event_o,
  output logic             accept_o,
  output logic             rising_o
);

  logic [Width-1:0] stab_q, stab_d;
  logic             filt_q, filt_d;
  logic             event_q, event_d;
  logic             differ;

  assign differ   = (pin_i != filt_q);
  // >= rather than == so a depth lowered mid-count cannot let stab_q wrap.
  assign accept_o = enable_i && !clear_i && differ && (stab_q >= depth_i);
  assign rising_o = pin_i;

  always_comb begin
    stab_d  = stab_q;
    filt_d  = filt_q;
    event_d = 1'b0;
    if (clear_i) begin
      stab_d = '0;
      filt_d = pin_i;
    end else if (!enable_i) begin
      stab_d = '0;
    end else if (!differ) begin
      stab_d = '0;
    end else if (accept_o) begin
      stab_d  = '0;
      filt_d  = pin_i;
      event_d = 1'b1;
    end else begin
      stab_d = stab_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q  <= '0;
      filt_q  <= 1'b0;
      event_q <= 1'b0;
    end else if (clk_en) begin
      stab_q  <= stab_d;
      filt_q  <= filt_d;
      event_q <= event_d;
    end
  end

  assign filtered_pin_o = filt_q;
  assign event_o        = event_q;

endmodule

// File: rtl/rate_tracker.sv
// Edge-event generation, edge-to-edge rate accumulator and active-rate register for lockin.
module rate_tracker
  import clks_alot_p::*;
#(
  parameter int unsigned FILTER_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          tracker_en_i,
  input  logic                          clear_state_i,
  input  logic                          pin_i,
  input  polarity_select_e              polarity_select_i,
  input  logic [FILTER_WIDTH-1:0]       filter_depth_i,
  input  logic                          update_rate_i,
  input  logic                          clear_rate_i,
  output logic                          filtered_pin_o,
  output logic                          filtered_event_o,
  output logic                          polarity_filtered_event_o,
  output logic [RATE_COUNTER_WIDTH-1:0] rate_accumulator_o,
  output logic [RATE_COUNTER_WIDTH-1:0] active_rate_o,
  output logic                          active_rate_valid_o,
  output logic                          accumulator_overflow_o
);

  localparam logic [RATE_COUNTER_WIDTH-1:0] AccMax = '1;
  localparam logic [RATE_COUNTER_WIDTH-1:0] AccOne = {{(RATE_COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic                          accept, rising, pol_match, acc_sat;
  logic                          primed_q, primed_d;
  logic                          pol_event_q, pol_event_d;
  logic                          overflow_q, overflow_d;
  logic                          valid_q, valid_d;
  logic [RATE_COUNTER_WIDTH-1:0] accum_q, accum_d;
  logic [RATE_COUNTER_WIDTH-1:0] active_q, active_d;

  glitch_filter #(
    .Width (FILTER_WIDTH)
  ) u_glitch_filter (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .clear_i        (clear_state_i),
    .enable_i       (tracker_en_i),
    .pin_i          (pin_i),
    .depth_i        (filter_depth_i),
    .filtered_pin_o (filtered_pin_o),
    .event_o        (filtered_event_o),
    .accept_o       (accept),
    .rising_o       (rising)
  );

  assign acc_sat = (accum_q == AccMax);

  always_comb begin
    case (polarity_select_i)
      POL_RISING:  pol_match = rising;
      POL_FALLING: pol_match = !rising;
      POL_BOTH:    pol_match = 1'b1;
      default:     pol_match = 1'b0;
    endcase
  end

  always_comb begin
    primed_d    = primed_q;
    pol_event_d = 1'b0;
    overflow_d  = overflow_q;
    valid_d     = valid_q;
    accum_d     = accum_q;
    active_d    = active_q;
    if (clear_state_i) begin
      primed_d   = 1'b0;
      overflow_d = 1'b0;
      valid_d    = 1'b0;
      accum_d    = '0;
      active_d   = '0;
    end else if (!tracker_en_i) begin
      primed_d = 1'b0;
      accum_d  = '0;
    end else begin
      // The first accepted edge only arms the qualifier; it never fires it.
      pol_event_d = accept && pol_match && primed_q;
      primed_d    = primed_q || accept;
      if (clear_rate_i) begin
        accum_d = AccOne;
      end else if (acc_sat) begin
        overflow_d = 1'b1;
      end else begin
        accum_d = accum_q + AccOne;
      end
      if (update_rate_i && !acc_sat) begin
        active_d = accum_q;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q    <= 1'b0;
      pol_event_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      accum_q     <= '0;
      active_q    <= '0;
    end else if (clk_en) begin
      primed_q    <= primed_d;
      pol_event_q <= pol_event_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      accum_q     <= accum_d;
      active_q    <= active_d;
    end
  end

  assign polarity_filtered_event_o = pol_event_q;
  assign rate_accumulator_o        = accum_q;
  assign active_rate_o             = active_q;
  assign active_rate_valid_o       = valid_q;
  assign accumulator_overflow_o    = overflow_q;

endmodule

// File: tb/tb_rate_tracker.sv
// Directed bench for rate_tracker: priming, glitch rejection, polarity, collision, saturation.
module tb_rate_tracker;
  import clks_alot_p::*;

  localparam int unsigned FW = 4;
  localparam int unsigned RW = RATE_COUNTER_WIDTH;

  logic                 clk, rst_n, clk_en, tracker_en, clear_state, pin;
  polarity_select_e     pol_sel;
  logic [FW-1:0]        depth;
  logic                 update_rate, clear_rate, clear_rate_man, tie_clear;
  logic                 filt, ev, pol_ev, valid, ovf;
  logic [RW-1:0]        accum, active;

  int total = 0;
  int bad   = 0;

  // Models lockin: it restarts the accumulator from the filtered event pulse.
  assign clear_rate = tie_clear ? ev : clear_rate_man;

  rate_tracker #(
    .FILTER_WIDTH (FW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .clk_en                    (clk_en),
    .tracker_en_i              (tracker_en),
    .clear_state_i             (clear_state),
    .pin_i                     (pin),
    .polarity_select_i         (pol_sel),
    .filter_depth_i            (depth),
    .update_rate_i             (update_rate),
    .clear_rate_i              (clear_rate),
    .filtered_pin_o            (filt),
    .filtered_event_o          (ev),
    .polarity_filtered_event_o (pol_ev),
    .rate_accumulator_o        (accum),
    .active_rate_o             (active),
    .active_rate_valid_o       (valid),
    .accumulator_overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic soft_clear();
    clear_state = 1'b1;
    step();
    clear_state = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_filt"}, 32'(filt), 32'd0);
    chk({tag, "_ev"}, 32'(ev), 32'd0);
    chk({tag, "_pol"}, 32'(pol_ev), 32'd0);
    chk({tag, "_acc"}, 32'(accum), 32'd0);
    chk({tag, "_act"}, 32'(active), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; clk_en = 1'b1; tracker_en = 1'b1; clear_state = 1'b0; pin = 1'b0;
    pol_sel = POL_BOTH; depth = '0; update_rate = 1'b0; clear_rate_man = 1'b0;
    tie_clear = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    step();
    rst_n = 1'b1;

    // Priming: depth 2, both polarities, pin toggles every 10 cycles.
    depth = 4'd2; pol_sel = POL_BOTH; tie_clear = 1'b1; pin = 1'b0;
    soft_clear();
    for (int k = 1; k <= 55; k++) begin
      pin = ((k / 10) % 2) == 1;
      step();
      chk("prime_ev", 32'(ev), 32'((k >= 12) && (k % 10 == 2)));
      chk("prime_pol", 32'(pol_ev), 32'((k >= 22) && (k % 10 == 2)));
      if (k >= 22 && k % 10 == 2) chk("prime_acc", 32'(accum), 32'd10);
      if (k == 12) chk("prime_filt_rise", 32'(filt), 32'd1);
      if (k == 22) chk("prime_filt_fall", 32'(filt), 32'd0);
    end

    // Glitch rejection: depth 3, 3-sample glitch then 4-sample pulse.
    depth = 4'd3; tie_clear = 1'b0; pin = 1'b0;
    soft_clear();
    for (int k = 1; k <= 14; k++) begin
      pin = (k <= 3) || (k >= 9 && k <= 12);
      step();
      chk("glitch_ev", 32'(ev), 32'(k == 12));
      chk("glitch_filt", 32'(filt), 32'(k >= 12));
    end

    // Polarity: rising only, period-20 square wave, depth 0.
    depth = 4'd0; pol_sel = POL_RISING; tie_clear = 1'b1; pin = 1'b0;
    soft_clear();
    for (int k = 1; k <= 60; k++) begin
      pin = ((k / 10) % 2) == 1;
      step();
      chk("pol_ev", 32'(ev), 32'(k % 10 == 0));
      chk("pol_pol", 32'(pol_ev), 32'(k == 30 || k == 50));
      if (k >= 20 && k % 10 == 0) chk("pol_acc", 32'(accum), 32'd10);
    end

    // Update/clear collision at accumulator 37.
    tie_clear = 1'b0;
    soft_clear();
    repeat (37) step();
    chk("coll_pre_acc", 32'(accum), 32'd37);
    update_rate = 1'b1; clear_rate_man = 1'b1;
    step();
    update_rate = 1'b0; clear_rate_man = 1'b0;
    chk("coll_act", 32'(active), 32'd37);
    chk("coll_valid", 32'(valid), 32'd1);
    chk("coll_acc", 32'(accum), 32'd1);

    // Disable zeroes the accumulator but keeps the active rate.
    tracker_en = 1'b0;
    step();
    tracker_en = 1'b1;
    chk("dis_acc", 32'(accum), 32'd0);
    chk("dis_act", 32'(active), 32'd37);
    chk("dis_valid", 32'(valid), 32'd1);

    // Saturation.
    soft_clear();
    chk("sat_clr_act", 32'(active), 32'd0);
    chk("sat_clr_valid", 32'(valid), 32'd0);
    repeat ((1 << RW) - 1) step();
    chk("sat_full_acc", 32'(accum), 32'((1 << RW) - 1));
    chk("sat_full_ovf", 32'(ovf), 32'd0);
    step();
    chk("sat_hold_acc", 32'(accum), 32'((1 << RW) - 1));
    chk("sat_ovf", 32'(ovf), 32'd1);
    update_rate = 1'b1;
    step();
    update_rate = 1'b0;
    chk("sat_upd_act", 32'(active), 32'd0);
    chk("sat_upd_valid", 32'(valid), 32'd0);
    chk("sat_ovf_sticky", 32'(ovf), 32'd1);
    depth = 4'd15; pin = 1'b1;
    soft_clear();
    chk("sat_clr_acc", 32'(accum), 32'd0);
    chk("sat_clr_ovf", 32'(ovf), 32'd0);
    chk("sat_clr_filt", 32'(filt), 32'd1);
    chk("sat_clr_ev", 32'(ev), 32'd0);

    // clk_en gating holds accumulator and pulses.
    depth = 4'd0;
    repeat (3) step();
    chk("gate_pre_acc", 32'(accum), 32'd3);
    pin = 1'b0;
    step();
    chk("gate_ev", 32'(ev), 32'd1);
    chk("gate_acc", 32'(accum), 32'd4);
    clk_en = 1'b0; pin = 1'b1;
    repeat (5) step();
    chk("gate_hold_ev", 32'(ev), 32'd1);
    chk("gate_hold_acc", 32'(accum), 32'd4);
    chk("gate_hold_filt", 32'(filt), 32'd0);
    clk_en = 1'b1; pin = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ev", 32'(ev), 32'd0);
    chk("post_rst_acc", 32'(accum), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
